i2s_multi_mic_rx: RTL and testbench

//  I2S master receiver for NUM_MICS microphones sharing one SCK/WS pair, each with its own SD line.

---
 rtl/i2s_pkg.sv | 26 ++
 rtl/i2s_sck_ws_gen.sv | 88 ++++++++
 rtl/i2s_multi_mic_rx.sv | 119 +++++++++++
 tb/tb_i2s_multi_mic_rx.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S definitions: slot encoding, FSM states and parameter sanity checks
// for the multi-mic receiver.
package i2s_pkg;

   localparam logic I2S_LEFT  = 1'b0;
   localparam logic I2S_RIGHT = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } i2s_state_t;

   function automatic int unsigned i2s_cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic bit i2s_params_ok(input int unsigned num_mics,
                                        input int unsigned data_width,
                                        input int unsigned slot_width,
                                        input int unsigned clk_div);
      return (num_mics >= 1) && (num_mics <= 8) && (data_width >= 1) &&
             (slot_width >= data_width + 1) && (clk_div >= 2) && ((clk_div % 2) == 0);
   endfunction

endpackage

// File: rtl/i2s_sck_ws_gen.sv
// I2S master timing: SCK divider, slot bit counter, WS and the run/drain FSM.
// Exports single-cycle SCK edge strobes plus the current bit index and slot.
module i2s_sck_ws_gen
   import i2s_pkg::*;
#(
   parameter int unsigned SLOT_WIDTH = 32,
   parameter int unsigned CLK_DIV    = 4
) (
   input  logic                                    i_sys_clk,
   input  logic                                    i_sys_rst,
   input  logic                                    i_en,
   output logic                                    o_sck,
   output logic                                    o_ws,
   output logic                                    o_sck_rise,
   output logic                                    o_sck_fall,
   output logic [i2s_cnt_width(SLOT_WIDTH)-1:0]    o_bit_idx,
   output logic                                    o_slot
);

   localparam int unsigned HALF  = CLK_DIV / 2;
   localparam int unsigned DIV_W = i2s_cnt_width(HALF);
   localparam int unsigned BIT_W = i2s_cnt_width(SLOT_WIDTH);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SLOT_WIDTH - 1);

   i2s_state_t       r_state;
   i2s_state_t       w_next;
   logic [DIV_W-1:0] r_div;
   logic [BIT_W-1:0] r_bit;
   logic             r_sck;
   logic             r_ws;
   logic             w_tc;
   logic             w_wrap;

   assign w_tc       = (r_state != ST_IDLE) && (r_div == DIV_LAST);
   assign o_sck_rise = w_tc & ~r_sck;
   assign o_sck_fall = w_tc & r_sck;
   assign w_wrap     = o_sck_fall && (r_bit == BIT_LAST);

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (i_en) w_next = ST_RUN;
         ST_RUN:   if (!i_en) w_next = ST_DRAIN;
         ST_DRAIN: begin
            if (i_en)
               w_next = ST_RUN;
            else if (w_wrap && (r_ws == I2S_RIGHT))
               w_next = ST_IDLE;
         end
         default:  w_next = ST_IDLE;
      endcase
   end

   // Starting RUN with the bit counter at its last value makes the first SCK
   // fall a slot wrap, so WS goes 1->0 there and a left slot begins.
   always_ff @(posedge i_sys_clk) begin
      if (i_sys_rst) begin
         r_state <= ST_IDLE;
         r_div   <= '0;
         r_bit   <= '0;
         r_sck   <= 1'b0;
         r_ws    <= I2S_RIGHT;
      end else begin
         r_state <= w_next;
         if ((r_state == ST_IDLE) || (w_next == ST_IDLE)) begin
            r_div <= '0;
            r_sck <= 1'b0;
            r_ws  <= I2S_RIGHT;
            r_bit <= (w_next == ST_RUN) ? BIT_LAST : '0;
         end else begin
            r_div <= w_tc ? '0 : r_div + 1'b1;
            if (w_tc)
               r_sck <= ~r_sck;
            if (o_sck_fall)
               r_bit <= w_wrap ? '0 : r_bit + 1'b1;
            if (w_wrap)
               r_ws <= ~r_ws;
         end
      end
   end

   assign o_sck     = r_sck;
   assign o_ws      = r_ws;
   assign o_bit_idx = r_bit;
   assign o_slot    = r_ws;

endmodule

// File: rtl/i2s_multi_mic_rx.sv
// I2S master receiver for several mics on a shared SCK/WS: per-mic left/right
// deserialisers and a one-deep valid/ready frame output with sticky overrun.
module i2s_multi_mic_rx
   import i2s_pkg::*;
#(
   parameter int unsigned NUM_MICS   = 2,
   parameter int unsigned DATA_WIDTH = 24,
   parameter int unsigned SLOT_WIDTH = 32,
   parameter int unsigned CLK_DIV    = 4
) (
   input  logic                           i_sys_clk,
   input  logic                           i_sys_rst,
   input  logic                           i_en,
   input  logic [NUM_MICS-1:0]            i_sd,
   output logic                           o_sck,
   output logic                           o_ws,
   output logic [NUM_MICS*DATA_WIDTH-1:0] o_left_data,
   output logic [NUM_MICS*DATA_WIDTH-1:0] o_right_data,
   output logic                           o_vld,
   input  logic                           i_rdy,
   output logic                           o_overrun,
   input  logic                           i_clr
);

   localparam int unsigned BIT_W = i2s_cnt_width(SLOT_WIDTH);
   localparam int unsigned FW    = NUM_MICS * DATA_WIDTH;
   localparam logic [BIT_W-1:0] BIT_LSB  = BIT_W'(DATA_WIDTH);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SLOT_WIDTH - 1);

   if (!i2s_params_ok(NUM_MICS, DATA_WIDTH, SLOT_WIDTH, CLK_DIV)) begin : g_param_err
      $error("i2s_multi_mic_rx: illegal parameter combination");
   end

   logic             w_sck_rise;
   logic             w_sck_fall;
   logic             w_slot;
   logic [BIT_W-1:0] w_bit_idx;
   logic             w_in_data;
   logic             w_complete;
   logic             w_accept;
   logic [FW-1:0]    w_left_frame;
   logic [FW-1:0]    w_right_frame;
   logic [FW-1:0]    r_left_data;
   logic [FW-1:0]    r_right_data;
   logic             r_vld;
   logic             r_overrun;

   i2s_sck_ws_gen #(
      .SLOT_WIDTH (SLOT_WIDTH),
      .CLK_DIV    (CLK_DIV)
   ) u_gen (
      .i_sys_clk  (i_sys_clk),
      .i_sys_rst  (i_sys_rst),
      .i_en       (i_en),
      .o_sck      (o_sck),
      .o_ws       (o_ws),
      .o_sck_rise (w_sck_rise),
      .o_sck_fall (w_sck_fall),
      .o_bit_idx  (w_bit_idx),
      .o_slot     (w_slot)
   );

   assign w_in_data  = (w_bit_idx != '0) && (w_bit_idx <= BIT_LSB);
   assign w_complete = w_sck_rise && (w_slot == I2S_RIGHT) && (w_bit_idx == BIT_LSB);
   assign w_accept   = r_vld & i_rdy;

   for (genvar m = 0; m < NUM_MICS; m++) begin : g_mic
      logic [DATA_WIDTH-1:0] r_left_sh;
      logic [DATA_WIDTH-1:0] r_right_sh;

      // The right LSB arrives in the completion cycle, so the frame takes it directly.
      assign w_left_frame[m*DATA_WIDTH +: DATA_WIDTH]  = r_left_sh;
      assign w_right_frame[m*DATA_WIDTH +: DATA_WIDTH] = (r_right_sh << 1) | DATA_WIDTH'(i_sd[m]);

      always_ff @(posedge i_sys_clk) begin
         if (i_sys_rst) begin
            r_left_sh  <= '0;
            r_right_sh <= '0;
         end else if (w_sck_rise && w_in_data) begin
            if (w_slot == I2S_LEFT)
               r_left_sh <= (r_left_sh << 1) | DATA_WIDTH'(i_sd[m]);
            else
               r_right_sh <= (r_right_sh << 1) | DATA_WIDTH'(i_sd[m]);
         end else if (w_sck_fall && (w_bit_idx == BIT_LAST)) begin
            if (w_slot == I2S_RIGHT)
               r_left_sh <= '0;
            else
               r_right_sh <= '0;
         end
      end
   end

   always_ff @(posedge i_sys_clk) begin
      if (i_sys_rst) begin
         r_left_data  <= '0;
         r_right_data <= '0;
         r_vld        <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         if (w_complete && (!r_vld || i_rdy)) begin
            r_left_data  <= w_left_frame;
            r_right_data <= w_right_frame;
            r_vld        <= 1'b1;
         end else if (w_accept) begin
            r_vld <= 1'b0;
         end
         if (w_complete && r_vld && !i_rdy)
            r_overrun <= 1'b1;
         else if (i_clr)
            r_overrun <= 1'b0;
      end
   end

   assign o_left_data  = r_left_data;
   assign o_right_data = r_right_data;
   assign o_vld        = r_vld;
   assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_i2s_multi_mic_rx.sv
// Directed bench for i2s_multi_mic_rx: behavioural I2S mics on the SD lines,
// a table of frames with hand-computed packed outputs, and handshake/drain/reset sequences.
module tb_i2s_multi_mic_rx;

   localparam int NM = 2;
   localparam int DW = 24;

   typedef struct packed {
      logic [23:0] l0;
      logic [23:0] r0;
      logic [23:0] l1;
      logic [23:0] r1;
   } frame_t;

   typedef struct {
      frame_t      f;
      logic [47:0] exp_l;
      logic [47:0] exp_r;
   } vec_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            en  = 1'b0;
   logic            rdy = 1'b0;
   logic            clr = 1'b0;
   logic [NM-1:0]   sd  = '1;
   logic            sck;
   logic            ws;
   logic            vld;
   logic            ovr;
   logic [NM*DW-1:0] left;
   logic [NM*DW-1:0] right;

   i2s_multi_mic_rx #(
      .NUM_MICS   (NM),
      .DATA_WIDTH (DW),
      .SLOT_WIDTH (32),
      .CLK_DIV    (4)
   ) dut (
      .i_sys_clk    (clk),
      .i_sys_rst    (rst),
      .i_en         (en),
      .i_sd         (sd),
      .o_sck        (sck),
      .o_ws         (ws),
      .o_left_data  (left),
      .o_right_data (right),
      .o_vld        (vld),
      .i_rdy        (rdy),
      .o_overrun    (ovr),
      .i_clr        (clr)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   int     cyc = 0;
   int     sck_rises = 0;
   int     vld_rises = 0;
   int     ws_bad = 0;
   int     rise_last = 0, rise_prev = 0;
   int     wsf_last = 0, wsf_prev = 0;
   int     k = 0;
   logic   p_sck = 1'b0, p_ws = 1'b1, p_vld = 1'b0;
   frame_t q[$];
   frame_t cur = '0;
   vec_t   tbl[4];

   function automatic frame_t mk(input logic [23:0] l0, input logic [23:0] r0,
                                 input logic [23:0] l1, input logic [23:0] r1);
      frame_t f;
      f.l0 = l0; f.r0 = r0; f.l1 = l1; f.r1 = r1;
      return f;
   endfunction

   // Bit k of a slot carries sample bit DW-k; other slot positions are driven high as junk.
   function automatic logic sd_bit(input frame_t f, input int m, input logic w, input int kk);
      logic [23:0] s;
      if (kk < 1 || kk > DW) return 1'b1;
      if (w) s = (m == 0) ? f.r0 : f.r1;
      else   s = (m == 0) ? f.l0 : f.l1;
      return s[DW-kk];
   endfunction

   always @(negedge clk) begin
      cyc++;
      if (!p_sck && sck) begin
         sck_rises++;
         rise_prev = rise_last;
         rise_last = cyc;
      end
      if (ws !== p_ws) begin
         if (!(p_sck && !sck)) ws_bad++;
         if (ws === 1'b0) begin
            wsf_prev = wsf_last;
            wsf_last = cyc;
         end
      end
      if (!p_vld && vld) vld_rises++;
      if (p_sck && !sck) begin
         if (ws !== p_ws) begin
            k = 0;
            if (ws === 1'b0) begin
               if (q.size() > 0) cur = q.pop_front();
               else cur = '0;
            end
         end else begin
            k++;
         end
         for (int m = 0; m < NM; m++) sd[m] = sd_bit(cur, m, ws, k);
      end
      p_sck = sck;
      p_ws  = ws;
      p_vld = vld;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // which: 0 = o_vld high, 1 = o_ws low, 2 = o_ws high, 3 = o_overrun high
   task automatic wait_for(input string name, input int which, input int limit);
      bit hit = 0;
      for (int t = 0; t < limit && !hit; t++) begin
         step(1);
         case (which)
            0: hit = (vld === 1'b1);
            1: hit = (ws === 1'b0);
            2: hit = (ws === 1'b1);
            default: hit = (ovr === 1'b1);
         endcase
      end
      if (!hit) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: event not seen within %0d cycles, expected it", name, limit);
      end
   endtask

   int snap_sck, snap_vld;

   initial begin
      tbl[0] = '{mk(24'h800001, 24'h7FFFFF, 24'h123456, 24'hFEDCBA), 48'h123456800001, 48'hFEDCBA7FFFFF};
      tbl[1] = '{mk(24'h000000, 24'hFFFFFF, 24'hFFFFFF, 24'h000000), 48'hFFFFFF000000, 48'h000000FFFFFF};
      tbl[2] = '{mk(24'hA5A5A5, 24'h5A5A5A, 24'h000001, 24'h800000), 48'h000001A5A5A5, 48'h8000005A5A5A};
      tbl[3] = '{mk(24'hC0FFEE, 24'hBADBEE, 24'h0F0F0F, 24'hF0F0F0), 48'h0F0F0FC0FFEE, 48'hF0F0F0BADBEE};

      // Reset and idle
      step(3);
      rst = 1'b0;
      step(1);
      chk("rst_sck", sck, 1'b0);
      chk("rst_ws", ws, 1'b1);
      chk("rst_vld", vld, 1'b0);
      chk("rst_overrun", ovr, 1'b0);
      chk("rst_left", left, '0);
      chk("rst_right", right, '0);
      snap_sck = sck_rises;
      step(100);
      chk("idle_sck_edges", sck_rises - snap_sck, 0);
      chk("idle_ws", ws, 1'b1);
      chk("idle_vld_rises", vld_rises, 0);

      // Frame table with i_rdy held high
      foreach (tbl[i]) q.push_back(tbl[i].f);
      rdy = 1'b1;
      en  = 1'b1;
      wait_for("first_ws_fall", 1, 50);
      chk("first_ws_on_sck_fall", ws_bad, 0);
      for (int i = 0; i < 4; i++) begin
         wait_for($sformatf("vld_%0d", i), 0, 600);
         chk($sformatf("left_%0d", i), left, tbl[i].exp_l);
         chk($sformatf("right_%0d", i), right, tbl[i].exp_r);
         step(1);
         chk($sformatf("vld_pulse_%0d", i), vld, 1'b0);
      end
      chk("sck_period", rise_last - rise_prev, 4);
      chk("ws_period", wsf_last - wsf_prev, 256);

      // Backpressure: A held, B dropped, C then D loaded on the accept cycle
      q.push_back(mk(24'h111111, 24'h222222, 24'h333333, 24'h444444));
      q.push_back(mk(24'hAAAAAA, 24'hBBBBBB, 24'hCCCCCC, 24'hDDDDDD));
      q.push_back(mk(24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C));
      q.push_back(mk(24'hFFFFFE, 24'h000002, 24'h7FFFFE, 24'h800002));
      rdy = 1'b0;
      wait_for("vld_A", 0, 400);
      chk("left_A", left, 48'h333333111111);
      chk("ovr_A", ovr, 1'b0);
      step(200);
      chk("hold_vld_A", vld, 1'b1);
      chk("hold_right_A", right, 48'h444444222222);
      wait_for("overrun_B", 3, 100);
      chk("drop_left_keeps_A", left, 48'h333333111111);
      chk("drop_right_keeps_A", right, 48'h444444222222);
      chk("drop_vld", vld, 1'b1);
      rdy = 1'b1;
      step(1);
      chk("accept_A_vld_low", vld, 1'b0);
      rdy = 1'b0;
      chk("overrun_sticky", ovr, 1'b1);
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      chk("overrun_cleared", ovr, 1'b0);
      wait_for("vld_C", 0, 400);
      chk("left_C", left, 48'h070809010203);
      chk("right_C", right, 48'h0A0B0C040506);
      step(255);
      rdy = 1'b1;
      step(1);
      chk("same_cycle_vld", vld, 1'b1);
      chk("same_cycle_left_D", left, 48'h7FFFFEFFFFFE);
      chk("same_cycle_right_D", right, 48'h800002000002);
      chk("same_cycle_no_overrun", ovr, 1'b0);
      step(1);
      chk("accept_D_vld_low", vld, 1'b0);

      // Drain: i_en dropped mid-left slot
      q.push_back(mk(24'h135790, 24'h246801, 24'hABCDEF, 24'hFEDCBA));
      q.push_back(mk(24'hF0000F, 24'h0F00F0, 24'h123123, 24'h321321));
      wait_for("drain_ws_fall", 1, 300);
      step(40);
      en = 1'b0;
      snap_vld = vld_rises;
      wait_for("vld_E", 0, 300);
      chk("drain_left_E", left, 48'hABCDEF135790);
      chk("drain_right_E", right, 48'hFEDCBA246801);
      step(100);
      snap_sck = sck_rises;
      step(100);
      chk("drain_sck_stopped", sck_rises - snap_sck, 0);
      chk("drain_sck_low", sck, 1'b0);
      chk("drain_ws_high", ws, 1'b1);
      chk("drain_one_frame", vld_rises - snap_vld, 1);

      // Reset pulsed mid-right slot
      en = 1'b1;
      wait_for("rerun_ws_fall", 1, 50);
      wait_for("rerun_ws_rise", 2, 200);
      step(40);
      chk("pre_rst_no_vld", vld, 1'b0);
      rst = 1'b1;
      en  = 1'b0;
      step(1);
      rst = 1'b0;
      chk("midrst_sck", sck, 1'b0);
      chk("midrst_ws", ws, 1'b1);
      chk("midrst_vld", vld, 1'b0);
      chk("midrst_left", left, '0);
      chk("midrst_right", right, '0);
      snap_vld = vld_rises;
      step(150);
      chk("midrst_no_frame", vld_rises - snap_vld, 0);

      // First frame after restart is delivered
      q.push_back(mk(24'h00FF00, 24'hFF00FF, 24'h0F00F0, 24'hF00F00));
      en = 1'b1;
      wait_for("vld_G", 0, 600);
      chk("restart_left_G", left, 48'h0F00F000FF00);
      chk("restart_right_G", right, 48'hF00F00FF00FF);
      chk("ws_only_on_sck_fall", ws_bad, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
